// File: rtl/conv_pool2.sv
// 2x2 stride-2 signed max-pool over a raster stream with optional ReLU; odd trailing row/col dropped.
// Latency 1 beat-to-output; IN_TREADY drops only while a pooled result is stalled on the output.
module conv_pool2 #(
  parameter int OUTW = 28,
  parameter int MAXR = 9,
  parameter int MAXC = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(MAXR+1)-1:0]     cfg_rows,
  input  logic [$clog2(MAXC+1)-1:0]     cfg_cols,
  input  logic                          cfg_relu,
  input  logic signed [OUTW-1:0]        IN_TDATA,
  input  logic                          IN_TVALID,
  output logic                          IN_TREADY,
  output logic signed [OUTW-1:0]        OUT_TDATA,
  output logic                          OUT_TVALID,
  input  logic                          OUT_TREADY,
  output logic                          busy,
  output logic                          frame_done
);
  localparam int RW  = $clog2(MAXR+1);
  localparam int CW  = $clog2(MAXC+1);
  localparam int LBD = (MAXC + 1) / 2;
  localparam int LIW = (LBD > 1) ? $clog2(LBD) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [RW-1:0]          row_q, row_d, rows_q, rows_d;
  logic [CW-1:0]          col_q, col_d, cols_q, cols_d;
  logic                   relu_q, relu_d;
  logic signed [OUTW-1:0] hold_q, hold_d;
  logic signed [OUTW-1:0] out_dat_q, out_dat_d;
  logic                   out_vld_q, out_vld_d;
  logic                   done_q, done_d;
  logic signed [OUTW-1:0] lb_q [LBD];

  logic                   accept;
  logic [RW-1:0]          rows_eff;
  logic [CW-1:0]          cols_eff;
  logic                   relu_eff;
  logic signed [OUTW-1:0] v, h, lb_rd;
  logic [LIW-1:0]         lb_idx;
  logic                   lb_we;
  logic                   last_col, last_row;

  function automatic logic [RW-1:0] clamp_rows(input logic [RW-1:0] x);
    if (x == '0) return RW'(1);
    if (x > RW'(MAXR)) return RW'(MAXR);
    return x;
  endfunction

  function automatic logic [CW-1:0] clamp_cols(input logic [CW-1:0] x);
    if (x == '0) return CW'(1);
    if (x > CW'(MAXC)) return CW'(MAXC);
    return x;
  endfunction

  assign IN_TREADY  = !out_vld_q || OUT_TREADY;
  assign accept     = IN_TVALID && IN_TREADY;
  assign OUT_TDATA  = out_dat_q;
  assign OUT_TVALID = out_vld_q;
  assign busy       = (state_q == RUN);
  assign frame_done = done_q;

  // In IDLE the beat being accepted is the first of a frame, so it uses live config.
  always_comb begin
    rows_eff = (state_q == IDLE) ? clamp_rows(cfg_rows) : rows_q;
    cols_eff = (state_q == IDLE) ? clamp_cols(cfg_cols) : cols_q;
    relu_eff = (state_q == IDLE) ? cfg_relu : relu_q;
    v        = (relu_eff && IN_TDATA[OUTW-1]) ? '0 : IN_TDATA;
    h        = (hold_q > v) ? hold_q : v;
    lb_idx   = LIW'(col_q >> 1);
    lb_rd    = lb_q[lb_idx];
    last_col = (col_q == cols_eff - CW'(1));
    last_row = (row_q == rows_eff - RW'(1));
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    relu_d    = relu_q;
    hold_d    = hold_q;
    out_dat_d = out_dat_q;
    out_vld_d = out_vld_q && !OUT_TREADY;
    done_d    = accept && last_col && last_row;
    lb_we     = 1'b0;
    if (accept) begin
      if (state_q == IDLE) begin
        rows_d = rows_eff;
        cols_d = cols_eff;
        relu_d = relu_eff;
      end
      if (!col_q[0]) begin
        hold_d = v;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_vld_d = 1'b1;
        out_dat_d = (lb_rd > h) ? lb_rd : h;
      end
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      case (state_q)
        IDLE:    if (!(last_col && last_row)) state_d = RUN;
        RUN:     if (last_col && last_row) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      relu_q    <= 1'b0;
      hold_q    <= '0;
      out_dat_q <= '0;
      out_vld_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      relu_q    <= relu_d;
      hold_q    <= hold_d;
      out_dat_q <= out_dat_d;
      out_vld_q <= out_vld_d;
      done_q    <= done_d;
    end
  end

  // Each entry is written on an even row before any odd-row read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (lb_we) lb_q[lb_idx] <= h;
  end
endmodule
